// File: rtl/instr_feeder.sv
// instr_feeder: steps a loadable program onto the 9-bit processor's DIN, one word per
// processor T0 (plus the mvi immediate at T1), pacing itself on the processor's Done.
module instr_feeder #(
  parameter int AW = 4
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadAddr,
  input  logic [8:0]    LoadData,
  input  logic          Done,
  output logic [8:0]    Dout,
  output logic          Run,
  output logic          Busy,
  output logic          Halted,
  output logic          Err,
  output logic [7:0]    InstrCount
);

  localparam logic [8:0]    NOP  = 9'b000000000;
  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  typedef enum logic [2:0] {IDLE, ISSUE, IMM, WAIT, HALT} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [8:0]    mem [0:(1<<AW)-1];
  logic          start_q;
  logic          start_pend;

  logic [8:0] word;
  logic       halt_op;
  logic       mvi_op;
  logic       trunc;
  logic       start_edge;

  assign word       = mem[pc];
  assign halt_op    = word[8];
  assign mvi_op     = (word[8:6] == 3'b001);
  assign trunc      = mvi_op && (pc == LAST);
  assign start_edge = Start && !start_q;

  // Program memory is only writable while no program is in flight.
  always_ff @(posedge Clock) begin
    if (LoadEn && (state == IDLE || state == HALT))
      mem[LoadAddr] <= LoadData;
  end

  // Halt markers and a truncated mvi are replaced by a NOP so the processor never sees them.
  always_comb begin
    Dout = NOP;
    Run  = 1'b0;
    case (state)
      ISSUE: begin
        Run = 1'b1;
        if (!halt_op && !trunc)
          Dout = word;
      end
      IMM, WAIT: begin
        Run  = 1'b1;
        Dout = word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      pc         <= '0;
      Busy       <= 1'b0;
      Halted     <= 1'b0;
      Err        <= 1'b0;
      InstrCount <= 8'd0;
      start_q    <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      start_q <= Start;
      case (state)
        IDLE: begin
          // Done marks the end of a NOP, so the next cycle is a processor T0.
          if (Start && Done) begin
            pc    <= '0;
            Busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (halt_op || trunc) begin
            Busy   <= 1'b0;
            Halted <= 1'b1;
            Err    <= trunc;
            state  <= HALT;
          end else if (mvi_op) begin
            pc    <= pc + AW'(1);
            state <= IMM;
          end else begin
            state <= WAIT;
          end
        end
        IMM, WAIT: begin
          if (Done) begin
            if (InstrCount != 8'hFF)
              InstrCount <= InstrCount + 8'd1;
            if (pc == LAST) begin
              Busy   <= 1'b0;
              Halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc    <= pc + AW'(1);
              state <= ISSUE;
            end
          end
        end
        HALT: begin
          if ((start_edge || start_pend) && Done) begin
            pc         <= '0;
            Busy       <= 1'b1;
            Halted     <= 1'b0;
            Err        <= 1'b0;
            InstrCount <= 8'd0;
            start_pend <= 1'b0;
            state      <= ISSUE;
          end else if (start_edge) begin
            start_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: a behavioural 9-bit processor consumes Dout and produces Done.
module tb_instr_feeder;

  logic       Clock    = 1'b0;
  logic       Resetn   = 1'b1;
  logic       Start    = 1'b0;
  logic       LoadEn   = 1'b0;
  logic [3:0] LoadAddr = 4'd0;
  logic [8:0] LoadData = 9'd0;
  logic       Done;
  logic [8:0] Dout;
  logic       Run, Busy, Halted, Err;
  logic [7:0] InstrCount;

  int checks = 0;
  int errors = 0;
  logic [8:0] seen [$];

  always #5 Clock = ~Clock;

  instr_feeder #(.AW(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .LoadEn(LoadEn),
    .LoadAddr(LoadAddr), .LoadData(LoadData), .Done(Done), .Dout(Dout),
    .Run(Run), .Busy(Busy), .Halted(Halted), .Err(Err), .InstrCount(InstrCount)
  );

  // Processor model: always stepping, latches DIN at T0, Done combinational.
  logic [1:0] t;
  logic [8:0] ir, a, g;
  logic [8:0] rf [8];

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      t <= 2'd0; ir <= 9'd0; a <= 9'd0; g <= 9'd0;
      for (int i = 0; i < 8; i++) rf[i] <= 9'd0;
    end else begin
      case (t)
        2'd0: begin ir <= Dout; t <= 2'd1; end
        2'd1: begin
          case (ir[8:6])
            3'b000:         rf[ir[5:3]] <= rf[ir[2:0]];
            3'b001:         rf[ir[5:3]] <= Dout;
            3'b010, 3'b011: a <= rf[ir[5:3]];
            default: ;
          endcase
          t <= (ir[8:7] == 2'b01) ? 2'd2 : 2'd0;
        end
        2'd2: begin g <= ir[6] ? a - rf[ir[2:0]] : a + rf[ir[2:0]]; t <= 2'd3; end
        default: begin rf[ir[5:3]] <= g; t <= 2'd0; end
      endcase
    end
  end

  assign Done = ((t == 2'd1) && (ir[8:7] != 2'b01)) || (t == 2'd3);

  task automatic load_word(input logic [3:0] addr, input logic [8:0] data);
    @(negedge Clock);
    LoadEn = 1'b1; LoadAddr = addr; LoadData = data;
    @(negedge Clock);
    LoadEn = 1'b0;
  endtask

  // Starts the program and records Dout on every Run cycle until Run drops again.
  task automatic run_prog(input bit inject);
    bit started = 1'b0;
    bit fin = 1'b0;
    seen.delete();
    @(negedge Clock);
    Start = 1'b1;
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge Clock);
      LoadEn = 1'b0;
      if (Run) begin
        seen.push_back(Dout);
        started = 1'b1;
        Start = 1'b0;
        if (inject && seen.size() == 2) begin
          LoadEn = 1'b1; LoadAddr = 4'd0; LoadData = 9'o777;
        end
      end else if (started) begin
        fin = 1'b1;
      end
    end
    Start = 1'b0;
    checks++;
    if (fin !== 1'b1) begin
      errors++; $display("FAIL run_done: program end seen=%0b required=1", fin);
    end
  endtask

  task automatic test_reset;
    #1 Resetn = 1'b0;
    #1;
    checks++;
    if (Dout !== 9'd0) begin errors++; $display("FAIL rst_dout: got %o want 0", Dout); end
    checks++;
    if ({Run, Busy, Halted, Err} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags: got %b want 0000", {Run, Busy, Halted, Err});
    end
    checks++;
    if (InstrCount !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", InstrCount); end
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    load_word(4'd0, 9'o201);
    load_word(4'd1, 9'o400);
    @(negedge Clock);
    Start = 1'b1;
    for (int i = 0; i < 10 && !Run; i++) @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    checks++;
    if ({Run, Busy, Dout} !== {2'b11, 9'o201}) begin
      errors++; $display("FAIL rst_inflight: got run=%b busy=%b dout=%o want 1 1 201", Run, Busy, Dout);
    end
    Resetn = 1'b0;
    #1;
    checks++;
    if (Dout !== 9'd0) begin errors++; $display("FAIL rst_mid_dout: got %o want 0", Dout); end
    checks++;
    if ({Run, Busy, Halted, Err} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_flags: got %b want 0000", {Run, Busy, Halted, Err});
    end
    checks++;
    if (InstrCount !== 8'd0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", InstrCount); end
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic test_program_run;
    logic [8:0] exp_seq [9] = '{9'o100, 9'o005, 9'o110, 9'o003,
                                9'o201, 9'o201, 9'o201, 9'o201, 9'o000};
    load_word(4'd0, 9'o100); load_word(4'd1, 9'd5);
    load_word(4'd2, 9'o110); load_word(4'd3, 9'd3);
    load_word(4'd4, 9'o201); load_word(4'd5, 9'o400);
    run_prog(1'b0);
    checks++;
    if (seen.size() != 9) begin errors++; $display("FAIL prog_len: got %0d want 9", seen.size()); end
    for (int i = 0; i < 9 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== exp_seq[i]) begin
        errors++; $display("FAIL prog_dout[%0d]: got %o want %o", i, seen[i], exp_seq[i]);
      end
    end
    checks++;
    if (rf[0] !== 9'd8) begin errors++; $display("FAIL prog_r0: got %0d want 8", rf[0]); end
    checks++;
    if (InstrCount !== 8'd3) begin errors++; $display("FAIL prog_count: got %0d want 3", InstrCount); end
    checks++;
    if ({Halted, Err} !== 2'b10) begin
      errors++; $display("FAIL prog_halt: got halted=%b err=%b want 1 0", Halted, Err);
    end
  endtask

  task automatic test_truncated_mvi;
    bit bad = 1'b0;
    for (int i = 0; i < 15; i++) load_word(4'(i), 9'o000);
    load_word(4'd15, 9'o120);
    run_prog(1'b0);
    foreach (seen[i]) if (seen[i] !== 9'o000) bad = 1'b1;
    checks++;
    if (seen.size() != 31) begin errors++; $display("FAIL trunc_len: got %0d want 31", seen.size()); end
    checks++;
    if (bad) begin errors++; $display("FAIL trunc_dout: non-NOP word driven=%b want 0", bad); end
    checks++;
    if ({Halted, Err} !== 2'b11) begin
      errors++; $display("FAIL trunc_flags: got halted=%b err=%b want 1 1", Halted, Err);
    end
    checks++;
    if (InstrCount !== 8'd15) begin errors++; $display("FAIL trunc_count: got %0d want 15", InstrCount); end
  endtask

  task automatic test_end_of_memory;
    bit bad = 1'b0;
    bit late_run = 1'b0;
    for (int i = 0; i < 16; i++) load_word(4'(i), 9'o010);
    run_prog(1'b0);
    foreach (seen[i]) if (seen[i] !== 9'o010) bad = 1'b1;
    checks++;
    if (seen.size() != 32 || bad) begin
      errors++; $display("FAIL eom_seq: got len=%0d bad=%b want 32 0", seen.size(), bad);
    end
    checks++;
    if ({Halted, Err} !== 2'b10) begin
      errors++; $display("FAIL eom_flags: got halted=%b err=%b want 1 0", Halted, Err);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (Run) late_run = 1'b1;
    end
    checks++;
    if (late_run) begin errors++; $display("FAIL eom_wrap: run after halt=%b want 0", late_run); end
    checks++;
    if (InstrCount !== 8'd16) begin errors++; $display("FAIL eom_count: got %0d want 16", InstrCount); end
  endtask

  task automatic test_load_while_busy;
    load_word(4'd0, 9'o201);
    load_word(4'd1, 9'o400);
    run_prog(1'b1);
    checks++;
    if (InstrCount !== 8'd1) begin errors++; $display("FAIL lwb_count: got %0d want 1", InstrCount); end
    run_prog(1'b0);
    checks++;
    if (seen.size() != 5 || seen[0] !== 9'o201) begin
      errors++; $display("FAIL lwb_readback: got len=%0d first=%o want 5 201", seen.size(), seen[0]);
    end
    checks++;
    if (Halted !== 1'b1) begin errors++; $display("FAIL lwb_halt: got %b want 1", Halted); end
  endtask

  task automatic test_restart;
    int busy_n = 0;
    bit bad_dout = 1'b0;
    checks++;
    if (InstrCount !== 8'd1) begin errors++; $display("FAIL rs_pre_count: got %0d want 1", InstrCount); end
    @(negedge Clock);
    LoadEn = 1'b1; LoadAddr = 4'd0; LoadData = 9'o400; Start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge Clock);
      LoadEn = 1'b0;
      if (Busy) begin
        busy_n++;
        if (Dout !== 9'o000) bad_dout = 1'b1;
      end
    end
    checks++;
    if (busy_n != 1) begin errors++; $display("FAIL rs_busy: got %0d busy cycles want 1", busy_n); end
    checks++;
    if (bad_dout) begin errors++; $display("FAIL rs_dout: halt word driven=%b want 0", bad_dout); end
    checks++;
    if ({Halted, Err} !== 2'b10) begin
      errors++; $display("FAIL rs_flags: got halted=%b err=%b want 1 0", Halted, Err);
    end
    checks++;
    if (InstrCount !== 8'd0) begin errors++; $display("FAIL rs_count: got %0d want 0", InstrCount); end
    Start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_program_run();
    test_truncated_mvi();
    test_end_of_memory();
    test_load_while_busy();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Program sequencer that drives the instruction side of the 9-bit bus processor. It holds a small loadable program memory and presents each instruction word, and the immediate word for `mvi`, on the processor's `DIN` input. It asserts `Run`, then waits for the processor's `Done` before issuing the next word. It sits between the board-level load/start controls and the processor, replacing hand-entered switch instructions.

## Interface
- `AW`, 4: program memory address width; depth = 2**AW words.
- `Clock`  in  1: single clock, shared with the processor.
- `Resetn`  in  1: asynchronous, active-low reset; assert together with the processor's `Resetn`.
- `Start`  in  1: level; request program execution from address 0.
- `LoadEn`  in  1: write enable for program memory.
- `LoadAddr`  in  AW: program memory write address.
- `LoadData`  in  9: program memory write data.
- `Done`  in  1: processor `Done` (combinational in the processor, valid in the same cycle).
- `Dout`  out  9: drives processor `DIN`.
- `Run`  out  1: high while an instruction is in flight.
- `Busy`  out  1: high in ISSUE, IMM and WAIT.
- `Halted`  out  1: program ended (halt marker or end of memory).
- `Err`  out  1: program ended on a truncated `mvi`.
- `InstrCount`  out  8: completed instructions, saturating at 255.

## Operation
- Memory: 2**AW x 9. Synchronous write when `LoadEn`=1, but only in IDLE or HALT; ignored otherwise. Combinational read at `pc`. Contents are not cleared by reset.
- NOP word = 9'b000000000 (`mv R0,R0`). `Dout` = NOP in IDLE and HALT.
- Processor alignment: the processor latches `DIN` at every T0. The cycle after any cycle with `Done`=1 is T0.
- FSM states: IDLE, ISSUE, IMM, WAIT, HALT.
- **IDLE**: `Dout`=NOP, `Run`=0. If `Start`=1 and `Done`=1 in the same cycle, set `pc`=0, then go to ISSUE. Otherwise stay. The NOP loop guarantees `Done` recurs every 2 cycles.
- **ISSUE** (processor T0): `Dout`=mem[pc], `Run`=1.
  - Opcode = mem[pc][8:6].
  - Opcode 1xx (halt marker): do not issue. `Dout`=NOP, go to HALT. The NOP is latched harmlessly.
  - Opcode 001 with `pc`=2**AW-1 (immediate would wrap): `Dout`=NOP, set `Err`=1, go to HALT.
  - Opcode 001 otherwise: `pc`<=pc+1, go to IMM.
  - Opcode 000/010/011: go to WAIT.
- **IMM** (processor T1 of `mvi`): `Dout`=mem[pc] (immediate), `Run`=1. `Done`=1 is expected here; on it, complete the instruction (see below).
- **WAIT**: `Dout` holds the last issued word, `Run`=1. On `Done`=1, complete the instruction.
- **Completion**: `InstrCount`++ (saturating). If `pc`=2**AW-1, go to HALT. Else `pc`<=pc+1 and go to ISSUE.
- **HALT**: `Halted`=1, `Run`=0. `Err` and `InstrCount` are held.
  - `Start` rising edge (registered previous value 0, now 1) together with `Done`=1: clear `Halted`, `Err`, `InstrCount`, set `pc`=0, go to ISSUE.
  - A `Start` rising edge without `Done`=1 stays pending until the next `Done`.
- `Start` deassertion mid-program has no effect; the program runs to its end.
- Simultaneous `LoadEn` and a `Start` edge in HALT: the write completes and the start is taken. The ISSUE state reads the updated memory.

## Timing
- Reset values: state IDLE, `pc`=0, `Dout`=0, `Run`=0, `Busy`=0, `Halted`=0, `Err`=0, `InstrCount`=0, `Start` edge register=0.
- Reset mid-program returns to IDLE immediately (asynchronous). The processor must be reset in the same cycle.
- `Dout` and `Run` are combinational from state/`pc`/memory. All other outputs are registered.
- Cycles per instruction, ISSUE to next ISSUE:
  - `mv`: 2.
  - `mvi`: 2.
  - `add`/`sub`: 4 (ISSUE + 3 WAIT cycles, `Done` in the third).
- IDLE to first ISSUE: at most 2 cycles after `Start` is seen high.
- `Done` outside ISSUE/IMM/WAIT is used only for alignment. `Done` in ISSUE is ignored.

## Test plan
- **Reset**: `Resetn`=0 mid-WAIT -> all outputs at reset values in the same cycle; `Dout`=0 while in reset.
- **Program run**: load 0:9'o100, 1:9'd5, 2:9'o110, 3:9'd3, 4:9'o201, 5:9'o400; pulse `Start` -> `Dout` sequence 100,005,110,003,201(x4 cycles),000 (octal); R0=8 in the processor; `InstrCount`=3; `Halted`=1, `Err`=0.
- **Truncated mvi**: mem[15]=9'o120 with mem[0..14]=NOP -> 15 completions, then `Err`=1, `Halted`=1, `InstrCount`=15, and 9'o120 never driven.
- **End of memory**: all 16 words `mv R1,R0` -> `InstrCount`=16, `Halted`=1, `Err`=0, and no access to address 0 after wrap.
- **Load while busy**: `LoadEn`=1 during WAIT with addr 0 data 9'o777 -> mem[0] unchanged on readback after halt.
- **Restart**: in HALT, rewrite mem[0]=9'o400 in the same cycle as the `Start` rising edge -> halts immediately, `InstrCount`=0; holding `Start` high afterwards causes no further restart.
